// File: rtl/prg_monitor.sv
// rtl/prg_monitor.sv - byte-command engine driving the memory programmer port
//
// Accepts W/R/D command bytes from the UART receiver, performs writes, single
// reads and block dumps on the memory's second port, and returns result bytes
// to the UART transmitter.
//
// Ports:
//   clock     in   system clock, rising edge (also the memory's prg_clock)
//   reset_n   in   asynchronous active-low reset
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   rx_data   in   received byte
//   tx_valid  out  response byte available
//   tx_ready  in   transmitter accepts tx_data when high with tx_valid
//   tx_data   out  response byte
//   prg_we    out  memory write enable (one cycle per write command)
//   prg_MA    out  memory address
//   prg_WD    out  memory write data
//   prg_RD    in   memory read data, valid one cycle after prg_MA is sampled
//   busy      out  high whenever the engine is not idle
module prg_monitor #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       prg_we,
  output logic [7:0] prg_MA,
  output logic [7:0] prg_WD,
  input  logic [7:0] prg_RD,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The timer counts idle cycles 0..TIMEOUT_CYCLES-1; the abort fires on the
  // cycle that would make it reach TIMEOUT_CYCLES.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_DUMP  = 8'h44;
  localparam logic [7:0] REPLY_OK = 8'h4B;
  localparam logic [7:0] REPLY_BAD = 8'h3F;

  typedef enum logic [3:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    WRITE,
    R_ADDR,
    D_ADDR,
    D_LEN,
    RD_ISSUE,
    RD_WAIT,
    SEND
  } state_t;

  state_t          state;
  logic [7:0]      addr;
  logic [7:0]      wdata;
  logic [8:0]      count;
  logic [TW-1:0]   timer;
  logic            wait_state;

  assign prg_MA = addr;
  assign prg_WD = wdata;

  // States that are waiting for the next byte of a command.
  assign wait_state = (state == W_ADDR) || (state == W_DATA) ||
                      (state == R_ADDR) || (state == D_ADDR) ||
                      (state == D_LEN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= 8'h00;
      wdata    <= 8'h00;
      count    <= 9'd0;
      timer    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      prg_we   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      prg_we <= 1'b0;

      // Inter-byte timeout. A received byte always wins over the abort, so
      // the case statement below and this block never both move the state.
      if (wait_state) begin
        if (rx_valid) begin
          timer <= '0;
        end else if (timer == TIMER_LAST) begin
          timer <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          timer <= timer + TW'(1);
        end
      end else begin
        timer <= '0;
      end

      case (state)
        IDLE: begin
          if (rx_valid) begin
            busy <= 1'b1;
            case (rx_data)
              OP_WRITE: state <= W_ADDR;
              OP_READ:  state <= R_ADDR;
              OP_DUMP:  state <= D_ADDR;
              default: begin
                tx_data  <= REPLY_BAD;
                tx_valid <= 1'b1;
                count    <= 9'd1;
                state    <= SEND;
              end
            endcase
          end
        end
        W_ADDR: begin
          if (rx_valid) begin
            addr  <= rx_data;
            state <= W_DATA;
          end
        end
        W_DATA: begin
          if (rx_valid) begin
            wdata  <= rx_data;
            prg_we <= 1'b1;     // high for exactly the WRITE cycle
            state  <= WRITE;
          end
        end
        WRITE: begin
          tx_data  <= REPLY_OK;
          tx_valid <= 1'b1;
          count    <= 9'd1;
          state    <= SEND;
        end
        R_ADDR: begin
          if (rx_valid) begin
            addr  <= rx_data;
            count <= 9'd1;
            state <= RD_ISSUE;
          end
        end
        D_ADDR: begin
          if (rx_valid) begin
            addr  <= rx_data;
            state <= D_LEN;
          end
        end
        D_LEN: begin
          if (rx_valid) begin
            count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            state <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          // Memory samples prg_MA at the end of this cycle.
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          tx_data  <= prg_RD;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          // rx_valid is deliberately ignored here; tx_valid is always high.
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (count > 9'd1) begin
              count <= count - 9'd1;
              addr  <= addr + 8'd1;
              state <= RD_ISSUE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prg_monitor.md
# prg_monitor

Byte-command engine that owns the programmer port of the CDEC memory: it accepts command bytes from the host UART receiver, performs writes, single reads and block dumps on the RAM's second port (`prg_we`/`prg_MA`/`prg_WD`/`prg_RD`), and returns result bytes to the UART transmitter. It sits between the UART pair and the memory block. Its clock also drives the memory's `prg_clock` at the top level.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50_000_000: maximum idle cycles between bytes of one command before it is abandoned (1 s at 50 MHz).

Ports:
- `clock`  in  1  single system clock, rising edge; tied to the memory's `prg_clock` at top level.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8  received byte.
- `tx_valid`  out  1  response byte available.
- `tx_ready`  in  1  transmitter accepts `tx_data` when high with `tx_valid`.
- `tx_data`  out  8  response byte.
- `prg_we`  out  1  memory programmer write enable.
- `prg_MA`  out  8  memory programmer address.
- `prg_WD`  out  8  memory programmer write data.
- `prg_RD`  in  8  memory programmer read data; valid one cycle after `prg_MA` is sampled.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Commands:
  - `W A D` (0x57): write D to address A. Reply 0x4B ('K').
  - `R A` (0x52): read address A. Reply is the data byte.
  - `D A L` (0x44): dump L bytes starting at A. L = 0 means 256 bytes. Address increments mod 256 (0xFF wraps to 0x00).
  - Any other opcode in IDLE: reply 0x3F ('?').
- Registers:
  - `addr` (8 b), which drives `prg_MA` continuously.
  - `wdata` (8 b), which drives `prg_WD`.
  - `count` (9 b), the remaining response bytes including the current one.
  - Timeout counter.
- States and transitions:
  - IDLE: on `rx_valid`, decode the opcode.
    - 'W' → W_ADDR; 'R' → R_ADDR; 'D' → D_ADDR.
    - Other opcode: `tx_data` := 0x3F, `count` := 1, → SEND.
  - W_ADDR: on a byte, `addr` := byte → W_DATA.
  - W_DATA: on a byte, `wdata` := byte → WRITE.
  - WRITE: `prg_we` = 1 for exactly this cycle. Then `tx_data` := 0x4B, `count` := 1 → SEND.
  - R_ADDR: on a byte, `addr` := byte, `count` := 1 → RD_ISSUE.
  - D_ADDR: on a byte, `addr` := byte → D_LEN.
  - D_LEN: on a byte, `count` := (byte == 0 ? 256 : byte) → RD_ISSUE.
  - RD_ISSUE: the memory samples `prg_MA` at the end of this cycle → RD_WAIT.
  - RD_WAIT: `tx_data` := `prg_RD` → SEND.
  - SEND: hold `tx_valid` with `tx_data` stable until `tx_ready`. On acceptance:
    - If `count` > 1: `count`--, `addr`++ → RD_ISSUE.
    - Otherwise → IDLE.
- Receive flow control:
  - `rx_valid` bytes arriving outside IDLE/W_ADDR/W_DATA/R_ADDR/D_ADDR/D_LEN are dropped (no backpressure exists).
  - Dropped bytes are never queued.
- Timeout:
  - In W_ADDR, W_DATA, R_ADDR, D_ADDR and D_LEN, the counter clears on each `rx_valid`.
  - If it reaches TIMEOUT_CYCLES, the FSM returns to IDLE silently, with no write and no reply.
- `prg_we` is asserted only in WRITE.
- Address 0xFF on the programmer port reaches the RAM cell, not the I/O port. No special-casing.

## Timing
- Reset values: FSM = IDLE, `tx_valid` = 0, `tx_data` = 0x00, `prg_we` = 0, `prg_MA` = 0x00, `prg_WD` = 0x00, `busy` = 0, `count` = 0, timeout = 0.
- Reset mid-command aborts immediately. A `prg_we` pulse in flight is cut; no partial reply is emitted.
- All outputs are registered or decoded from state registers only. There is no combinational path from `rx_*`/`tx_ready` to outputs.
- Write latency: last byte sampled at edge E.
  - `prg_we` is high in cycle E..E+1 only.
  - `tx_valid` rises at E+1 (cycle E+1..E+2).
- Read latency: last byte sampled at edge E.
  - RD_ISSUE occupies E..E+1; RD_WAIT occupies E+1..E+2.
  - `tx_valid` rises at E+2.
- Dump throughput: at most one byte per 3 cycles (SEND ≥1, RD_ISSUE 1, RD_WAIT 1).
- Simultaneous events:
  - In SEND, `rx_valid` is ignored.
  - `tx_ready` high while `tx_valid` is low has no effect.

## Test plan
- Reset, then `W 0x10 0xA5`: exactly one `prg_we` cycle with MA = 0x10, WD = 0xA5. Reply 0x4B; `busy` then falls.
- Preload RAM[0x20] = 0x3C, send `R 0x20`: `tx_valid` asserts 2 cycles after the address byte. `tx_data` = 0x3C; no `prg_we`.
- `D 0xFE 0x03` with RAM[0xFE,0xFF,0x00] = 11,22,33 and random `tx_ready` stalls: reply 0x11, 0x22, 0x33 in order; `addr` wraps to 0x00.
- `D 0x00 0x00`: exactly 256 bytes, matching RAM[0x00..0xFF], then IDLE.
- Opcode 0x5A: reply 0x3F only, no memory access. Extra `rx_valid` bytes during SEND produce no effect.
- With TIMEOUT_CYCLES = 16, send `W 0x40` then idle 16 cycles, then `R 0x40`: no write occurs, the FSM returns to IDLE, and the read reply is the old RAM[0x40]. Assert `reset_n` low mid-dump: `tx_valid` drops to 0 immediately.
